// File: rtl/pu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pu_operand_fetch
// Description : Operand-fetch stage. Issues register-file reads, forwards
//               in-window writebacks and buffers operand bundles for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int OP_WIDTH   = 3,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [OP_WIDTH-1:0]   inst_op,
    input  logic [ADDR_WIDTH-1:0] inst_src0,
    input  logic [ADDR_WIDTH-1:0] inst_src1,
    input  logic [ADDR_WIDTH-1:0] inst_dst,
    output logic                  rf_rd_req_0,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr_0,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_0,
    output logic                  rf_rd_req_1,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr_1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data_1,
    input  logic                  wb_wr_req,
    input  logic [ADDR_WIDTH-1:0] wb_wr_addr,
    input  logic [DATA_WIDTH-1:0] wb_wr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_WIDTH-1:0]   out_op,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic [DATA_WIDTH-1:0] out_data_0,
    output logic [DATA_WIDTH-1:0] out_data_1
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = OP_WIDTH + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);

    // Inflight (read issued, data due this cycle) bundle
    logic                  r_inflight;
    logic [OP_WIDTH-1:0]   r_op;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_src0;
    logic [ADDR_WIDTH-1:0] r_src1;
    logic                  r_fwd_hit_0;
    logic                  r_fwd_hit_1;
    logic [DATA_WIDTH-1:0] r_fwd_0;
    logic [DATA_WIDTH-1:0] r_fwd_1;

    logic [c_ENTRY_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [c_CNT_W:0]      w_credits_used;
    logic                  w_hit_acc_0;
    logic                  w_hit_acc_1;
    logic                  w_hit_inf_0;
    logic                  w_hit_inf_1;
    logic [DATA_WIDTH-1:0] w_push_data_0;
    logic [DATA_WIDTH-1:0] w_push_data_1;

    // Credit counts the inflight slot so a capture always has room in the FIFO
    assign w_credits_used = {{c_CNT_W{1'b0}}, r_inflight} + {1'b0, r_count};
    assign inst_ready     = resetn && (w_credits_used < c_DEPTH);
    assign w_accept       = inst_valid && inst_ready;

    assign rf_rd_req_0  = w_accept;
    assign rf_rd_req_1  = w_accept;
    assign rf_rd_addr_0 = inst_src0;
    assign rf_rd_addr_1 = inst_src1;

    assign w_hit_acc_0 = wb_wr_req && (wb_wr_addr == inst_src0);
    assign w_hit_acc_1 = wb_wr_req && (wb_wr_addr == inst_src1);
    assign w_hit_inf_0 = wb_wr_req && (wb_wr_addr == r_src0);
    assign w_hit_inf_1 = wb_wr_req && (wb_wr_addr == r_src1);

    // A write in the inflight cycle commits on the capture edge, so it wins
    assign w_push_data_0 = w_hit_inf_0 ? wb_wr_data :
                           r_fwd_hit_0 ? r_fwd_0    : rf_rd_data_0;
    assign w_push_data_1 = w_hit_inf_1 ? wb_wr_data :
                           r_fwd_hit_1 ? r_fwd_1    : rf_rd_data_1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight  <= 1'b0;
            r_op        <= '0;
            r_dst       <= '0;
            r_src0      <= '0;
            r_src1      <= '0;
            r_fwd_hit_0 <= 1'b0;
            r_fwd_hit_1 <= 1'b0;
            r_fwd_0     <= '0;
            r_fwd_1     <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_op        <= inst_op;
                r_dst       <= inst_dst;
                r_src0      <= inst_src0;
                r_src1      <= inst_src1;
                r_fwd_hit_0 <= w_hit_acc_0;
                r_fwd_hit_1 <= w_hit_acc_1;
                r_fwd_0     <= wb_wr_data;
                r_fwd_1     <= wb_wr_data;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign w_push    = r_inflight;
    assign w_pop     = out_valid && out_ready;

    assign {out_op, out_dst, out_data_0, out_data_1} = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {r_op, r_dst, w_push_data_0, w_push_data_1};
                r_wr_ptr         <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pu_operand_fetch
// Description : Directed + random bench with register-file model and
//               architectural-state reference model for pu_operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_operand_fetch;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int OW    = 3;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_valid;
    logic          inst_ready;
    logic [OW-1:0] inst_op;
    logic [AW-1:0] inst_src0, inst_src1, inst_dst;
    logic          rf_rd_req_0, rf_rd_req_1;
    logic [AW-1:0] rf_rd_addr_0, rf_rd_addr_1;
    logic [DW-1:0] rf_rd_data_0, rf_rd_data_1;
    logic          wb_wr_req;
    logic [AW-1:0] wb_wr_addr;
    logic [DW-1:0] wb_wr_data;
    logic          out_valid, out_ready;
    logic [OW-1:0] out_op;
    logic [AW-1:0] out_dst;
    logic [DW-1:0] out_data_0, out_data_1;

    int vectors     = 0;
    int miscompares = 0;

    pu_operand_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
        .inst_src0(inst_src0), .inst_src1(inst_src1), .inst_dst(inst_dst),
        .rf_rd_req_0(rf_rd_req_0), .rf_rd_addr_0(rf_rd_addr_0), .rf_rd_data_0(rf_rd_data_0),
        .rf_rd_req_1(rf_rd_req_1), .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_data_1(rf_rd_data_1),
        .wb_wr_req(wb_wr_req), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_dst(out_dst),
        .out_data_0(out_data_0), .out_data_1(out_data_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Register file: 1-cycle registered read, read-before-write on the same edge.
    // Unrequested read ports return garbage so stale data cannot go unnoticed.
    logic [DW-1:0] rf [16];
    logic          rq0_s, rq1_s;
    logic [AW-1:0] ra0_s, ra1_s;

    always @(negedge clk) begin
        rq0_s <= rf_rd_req_0;
        rq1_s <= rf_rd_req_1;
        ra0_s <= rf_rd_addr_0;
        ra1_s <= rf_rd_addr_1;
    end

    always @(posedge clk) begin
        rf_rd_data_0 <= rq0_s ? rf[ra0_s] : DW'($urandom);
        rf_rd_data_1 <= rq1_s ? rf[ra1_s] : DW'($urandom);
        if (wb_wr_req) rf[wb_wr_addr] <= wb_wr_data;
    end

    // Reference model: an accepted instruction's operands are the architectural
    // register values once the writes of its accept and following edge are done;
    // bundles leave in order and the stage holds at most DEPTH instructions.
    typedef struct {
        logic [OW-1:0] op;
        logic [AW-1:0] dst;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          exp_q[$];
    bit            pend = 1'b0;
    exp_t          pend_e;
    logic [AW-1:0] pend_s0, pend_s1;
    logic [DW-1:0] m_regs [16];
    logic [DW-1:0] after  [16];

    always @(negedge clk) begin
        exp_t e;
        bit   exp_rdy;
        if (!resetn) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            exp_rdy = (int'(pend) + exp_q.size()) < DEPTH;
            chk("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
            chk("inst_ready", DW'(inst_ready), DW'(exp_rdy));
            chk("rd_req_0", DW'(rf_rd_req_0), DW'(inst_valid && exp_rdy));
            chk("rd_req_1", DW'(rf_rd_req_1), DW'(inst_valid && exp_rdy));
            if (inst_valid && exp_rdy) begin
                chk("rd_addr_0", DW'(rf_rd_addr_0), DW'(inst_src0));
                chk("rd_addr_1", DW'(rf_rd_addr_1), DW'(inst_src1));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_op", DW'(out_op), DW'(e.op));
                chk("out_dst", DW'(out_dst), DW'(e.dst));
                chk("out_data_0", out_data_0, e.d0);
                chk("out_data_1", out_data_1, e.d1);
            end
            after = m_regs;
            if (wb_wr_req) after[wb_wr_addr] = wb_wr_data;
            if (pend) begin
                pend_e.d0 = after[pend_s0];
                pend_e.d1 = after[pend_s1];
                exp_q.push_back(pend_e);
            end
            pend = inst_valid && inst_ready;
            if (pend) begin
                pend_e.op  = inst_op;
                pend_e.dst = inst_dst;
                pend_s0    = inst_src0;
                pend_s1    = inst_src1;
            end
        end
        if (wb_wr_req) m_regs[wb_wr_addr] = wb_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic [OW-1:0] op, input logic [AW-1:0] s0,
                              input logic [AW-1:0] s1, input logic [AW-1:0] dst);
        inst_valid = 1'b1;
        inst_op    = op;
        inst_src0  = s0;
        inst_src1  = s1;
        inst_dst   = dst;
    endtask

    task automatic drive_rand();
        drive_inst(OW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
    endtask

    task automatic drive_wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_wr_req  = en;
        wb_wr_addr = a;
        wb_wr_data = d;
    endtask

    initial begin
        int n;
        bit acc;
        resetn     = 1'b0;
        out_ready  = 1'b0;
        drive_wb(1'b0, '0, '0);
        drive_inst('0, '0, '0, '0);
        inst_valid = 1'b1;

        // Reset state: no ready, no reads, outputs cleared
        @(negedge clk);
        chk("rst_inst_ready", DW'(inst_ready), '0);
        chk("rst_rd_req", DW'(rf_rd_req_0), '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data_0", out_data_0, '0);
        chk("rst_out_op", DW'(out_op), '0);
        tick();
        inst_valid = 1'b0;
        tick();
        resetn = 1'b1;

        // Preload every register
        for (int a = 0; a < 16; a++) begin
            case (a)
                3:       drive_wb(1'b1, AW'(a), 32'hA5);
                7:       drive_wb(1'b1, AW'(a), 32'h5A);
                5:       drive_wb(1'b1, AW'(a), 32'h0);
                4:       drive_wb(1'b1, AW'(a), 32'h0F);
                default: drive_wb(1'b1, AW'(a), DW'($urandom));
            endcase
            tick();
        end
        drive_wb(1'b0, '0, '0);

        // Basic fetch and two-cycle latency
        out_ready = 1'b1;
        drive_inst(3'd2, 4'd3, 4'd7, 4'd1);
        @(negedge clk);
        chk("t1_ready", DW'(inst_ready), 1);
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        chk("t1_not_yet", DW'(out_valid), '0);
        tick();
        @(negedge clk);
        chk("t1_valid", DW'(out_valid), 1);
        chk("t1_data_0", out_data_0, 32'hA5);
        chk("t1_data_1", out_data_1, 32'h5A);
        chk("t1_op", DW'(out_op), 2);
        chk("t1_dst", DW'(out_dst), 1);
        tick();

        // Back-to-back stream at full rate
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive_rand(); else inst_valid = 1'b0;
            @(negedge clk);
            if (i < 8)  chk("t2_ready", DW'(inst_ready), 1);
            if (i >= 2) chk("t2_stream_valid", DW'(out_valid), 1);
            tick();
        end
        inst_valid = 1'b0;
        @(negedge clk);
        chk("t2_stream_end", DW'(out_valid), '0);
        tick();

        // Backpressure: exactly DEPTH accepts, then drain in order
        out_ready = 1'b0;
        drive_rand();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = inst_ready;
            if (acc) n++;
            tick();
            if (acc) drive_rand();
        end
        chk("t3_accepts", DW'(n), DW'(DEPTH));
        @(negedge clk);
        chk("t3_stalled", DW'(inst_ready), '0);
        tick();
        inst_valid = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n++;
            tick();
        end
        chk("t3_drained", DW'(n), DW'(DEPTH));

        // Forwarding of a write in the accept cycle
        drive_inst(3'd1, 4'd5, 4'd9, 4'd2);
        drive_wb(1'b1, 4'd5, 32'h1234);
        tick();
        inst_valid = 1'b0;
        drive_wb(1'b0, '0, '0);
        tick();
        @(negedge clk);
        chk("t4_acc_fwd", out_data_0, 32'h1234);
        tick();

        // Forwarding of a write in the inflight cycle
        drive_inst(3'd3, 4'd5, 4'd9, 4'd2);
        tick();
        inst_valid = 1'b0;
        drive_wb(1'b1, 4'd5, 32'h9999);
        tick();
        drive_wb(1'b0, '0, '0);
        @(negedge clk);
        chk("t4_inf_fwd", out_data_0, 32'h9999);
        tick();

        // A write after capture must not disturb the buffered bundle
        out_ready = 1'b0;
        drive_inst(3'd4, 4'd5, 4'd9, 4'd2);
        tick();
        inst_valid = 1'b0;
        tick();
        drive_wb(1'b1, 4'd5, 32'h7777);
        tick();
        drive_wb(1'b0, '0, '0);
        @(negedge clk);
        chk("t4_late_wb_valid", DW'(out_valid), 1);
        chk("t4_late_wb_hold", out_data_0, 32'h9999);
        out_ready = 1'b1;
        tick();

        // Same source on both ports with an accept-cycle write
        drive_inst(3'd5, 4'd4, 4'd4, 4'd6);
        drive_wb(1'b1, 4'd4, 32'hF0);
        tick();
        inst_valid = 1'b0;
        drive_wb(1'b0, '0, '0);
        tick();
        @(negedge clk);
        chk("t5_data_0", out_data_0, 32'hF0);
        chk("t5_data_1", out_data_1, 32'hF0);
        tick();

        // Asynchronous reset with two buffered and one inflight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        inst_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid", DW'(out_valid), '0);
        chk("t6_rst_ready", DW'(inst_ready), '0);
        tick();
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_empty", DW'(out_valid), '0);
        chk("t6_ready", DW'(inst_ready), 1);
        chk("t6_cleared_data", out_data_0, '0);
        tick();
        out_ready = 1'b1;
        drive_inst(3'd7, 4'd3, 4'd7, 4'd8);
        tick();
        inst_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_after_valid", DW'(out_valid), 1);
        chk("t6_after_data_0", out_data_0, 32'hA5);
        chk("t6_after_data_1", out_data_1, 32'h5A);
        tick();

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) drive_rand(); else inst_valid = 1'b0;
            out_ready = ($urandom_range(2) != 0);
            drive_wb(1'($urandom), AW'($urandom), DW'($urandom));
            tick();
        end
        inst_valid = 1'b0;
        out_ready  = 1'b1;
        drive_wb(1'b0, '0, '0);
        repeat (8) tick();
        @(negedge clk);
        chk("final_drained", DW'(out_valid), '0);
        chk("final_model_empty", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
